// File: rtl/filt_sample_sequencer.sv
// Sequences one XADC sample at a time through the filters core: latch, start pulse, wait for done, return result.
// Single transaction in flight; WAIT is supervised by a timeout that raises a sticky error and abandons the sample.
module filt_sample_sequencer #(
   parameter int XADC_DATA_SIZE = 16,
   parameter int START_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                cfg_sel,
   input  logic                      s_valid,
   input  logic [XADC_DATA_SIZE-1:0] s_data,
   output logic                      s_ready,
   output logic                      filt_start,
   output logic [1:0]                filt_select,
   output logic [XADC_DATA_SIZE-1:0] filt_input,
   input  logic [XADC_DATA_SIZE-1:0] filt_result,
   input  logic                      filt_done,
   output logic                      m_valid,
   output logic [XADC_DATA_SIZE-1:0] m_data,
   output logic [1:0]                m_sel,
   input  logic                      m_ready,
   output logic                      busy,
   output logic                      err_timeout,
   input  logic                      err_clr,
   output logic [CNT_W-1:0]          sample_cnt
);

   localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [SC_W-1:0] START_LAST = SC_W'(START_CYCLES - 1);
   localparam logic [TO_W-1:0] WAIT_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t                    state_q,      state_d;
   logic [SC_W-1:0]           start_cnt_q,  start_cnt_d;
   logic [TO_W-1:0]           wait_cnt_q,   wait_cnt_d;
   logic                      done_q;
   logic [XADC_DATA_SIZE-1:0] filt_input_q, filt_input_d;
   logic [1:0]                filt_sel_q,   filt_sel_d;
   logic [XADC_DATA_SIZE-1:0] m_data_q,     m_data_d;
   logic [1:0]                m_sel_q,      m_sel_d;
   logic                      m_valid_q,    m_valid_d;
   logic                      err_q,        err_d;
   logic [CNT_W-1:0]          cnt_q,        cnt_d;
   logic                      done_edge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         start_cnt_q  <= '0;
         wait_cnt_q   <= '0;
         done_q       <= 1'b0;
         filt_input_q <= '0;
         filt_sel_q   <= '0;
         m_data_q     <= '0;
         m_sel_q      <= '0;
         m_valid_q    <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         start_cnt_q  <= start_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         done_q       <= filt_done;
         filt_input_q <= filt_input_d;
         filt_sel_q   <= filt_sel_d;
         m_data_q     <= m_data_d;
         m_sel_q      <= m_sel_d;
         m_valid_q    <= m_valid_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

   // Only a rising edge of the done level counts, so a level left high by a previous job is ignored.
   assign done_edge = filt_done & ~done_q;

   always_comb begin
      state_d      = state_q;
      start_cnt_d  = start_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      filt_input_d = filt_input_q;
      filt_sel_d   = filt_sel_q;
      m_data_d     = m_data_q;
      m_sel_d      = m_sel_q;
      m_valid_d    = m_valid_q;
      cnt_d        = cnt_q;
      err_d        = err_clr ? 1'b0 : err_q;

      case (state_q)
         S_IDLE: begin
            if (s_valid) begin
               filt_input_d = s_data;
               filt_sel_d   = cfg_sel;
               start_cnt_d  = '0;
               state_d      = S_START;
            end
         end
         S_START: begin
            if (start_cnt_q == START_LAST) begin
               wait_cnt_d = '0;
               state_d    = S_WAIT;
            end else begin
               start_cnt_d = start_cnt_q + 1'b1;
            end
         end
         S_WAIT: begin
            // A done edge landing on the final timeout cycle still completes the transaction.
            if (done_edge) begin
               m_data_d  = filt_result;
               m_sel_d   = filt_sel_q;
               m_valid_d = 1'b1;
               state_d   = S_OUT;
            end else if (wait_cnt_q == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               cnt_d     = cnt_q + 1'b1;
               state_d   = S_IDLE;
            end
         end
      endcase
   end

   assign s_ready     = (state_q == S_IDLE) & ~rst;
   assign filt_start  = (state_q == S_START);
   assign busy        = (state_q != S_IDLE);
   assign filt_input  = filt_input_q;
   assign filt_select = filt_sel_q;
   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign m_sel       = m_sel_q;
   assign err_timeout = err_q;
   assign sample_cnt  = cnt_q;

endmodule

// File: tb/tb_filt_sample_sequencer.sv
// Bench for filt_sample_sequencer: scripted filters-core model, scoreboard of expected results.
module tb_filt_sample_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  cfg_sel;
   logic        s_valid;
   logic [15:0] s_data;
   logic        s_ready;
   logic        filt_start;
   logic [1:0]  filt_select;
   logic [15:0] filt_input;
   logic [15:0] filt_result;
   logic        filt_done;
   logic        m_valid;
   logic [15:0] m_data;
   logic [1:0]  m_sel;
   logic        m_ready;
   logic        busy;
   logic        err_timeout;
   logic        err_clr;
   logic [15:0] sample_cnt;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  sel;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_cnt = '0;

   filt_sample_sequencer #(
      .XADC_DATA_SIZE(16),
      .START_CYCLES  (2),
      .TIMEOUT_CYCLES(20),
      .CNT_W         (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_sel    (cfg_sel),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .filt_start (filt_start),
      .filt_select(filt_select),
      .filt_input (filt_input),
      .filt_result(filt_result),
      .filt_done  (filt_done),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_sel      (m_sel),
      .m_ready    (m_ready),
      .busy       (busy),
      .err_timeout(err_timeout),
      .err_clr    (err_clr),
      .sample_cnt (sample_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference filters-core arithmetic used to build the golden results.
   function automatic logic [15:0] core_model(input logic [15:0] smp, input logic [1:0] sel);
      case (sel)
         2'b00:   core_model = (smp >> 1) + 16'd3;
         2'b01:   core_model = smp ^ 16'hA5A5;
         default: core_model = ~smp;
      endcase
   endfunction

   // One transaction: handshake, start pulse, done after dly cycles, hold cycles of output backpressure.
   task automatic run_txn(input logic [15:0] smp, input logic [1:0] sel, input int dly,
                          input logic [15:0] res, input int hold, input bit stale);
      exp_t e;
      if (stale) begin
         filt_done   = 1'b1;
         filt_result = 16'hDEAD;
      end
      chk("s_ready_idle", s_ready, 1);
      s_valid = 1'b1;
      s_data  = smp;
      cfg_sel = sel;
      sb.push_back('{res, sel});
      tick();
      s_valid = 1'b0;
      s_data  = ~smp;
      cfg_sel = ~sel;
      chk("start_c1", filt_start, 1);
      chk("filt_input", filt_input, smp);
      chk("filt_select", filt_select, sel);
      chk("busy", busy, 1);
      tick();
      chk("start_c2", filt_start, 1);
      tick();
      chk("start_end", filt_start, 0);
      repeat (dly - 2) tick();
      if (stale) begin
         chk("stale_no_cap", m_valid, 0);
         filt_done = 1'b0;
         tick();
      end
      filt_done   = 1'b1;
      filt_result = res;
      tick();
      chk("m_valid_rise", m_valid, 1);
      chk("no_err", err_timeout, 0);
      filt_done   = 1'b0;
      filt_result = ~res;
      m_ready     = 1'b0;
      for (int i = 0; i < hold; i++) begin
         chk("bp_valid", m_valid, 1);
         chk("bp_s_ready", s_ready, 0);
         s_valid = 1'b1;
         tick();
      end
      s_valid = 1'b0;
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, res);
      m_ready = 1'b1;
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("sb_data", m_data, e.data);
         chk("sb_sel", m_sel, e.sel);
      end
      tick();
      m_ready = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      chk("m_valid_fall", m_valid, 0);
      chk("s_ready_after", s_ready, 1);
      chk("sample_cnt", sample_cnt, exp_cnt);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_cnt = '0;
      tick();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cfg_sel = '0; s_valid = 1'b0; s_data = '0;
      filt_result = '0; filt_done = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
      tick();
      chk("rst_s_ready", s_ready, 0);
      chk("rst_start", filt_start, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", sample_cnt, 0);
      chk("rst_err", err_timeout, 0);
      tick();
      rst = 1'b0;
      tick();

      // Single sample, then backpressure
      run_txn(16'd1234, 2'b01, 10, 16'd777, 0, 1'b0);
      run_txn(16'd4321, 2'b10, 6, 16'h0BEE, 5, 1'b0);

      // Timeout: core never answers
      s_valid = 1'b1; s_data = 16'd42; cfg_sel = 2'b00;
      tick();
      s_valid = 1'b0;
      tick();
      tick();
      repeat (19) tick();
      chk("to_pre_err", err_timeout, 0);
      chk("to_pre_busy", busy, 1);
      tick();
      chk("to_err", err_timeout, 1);
      chk("to_idle", busy, 0);
      chk("to_no_valid", m_valid, 0);
      chk("to_cnt", sample_cnt, exp_cnt);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("to_clr", err_timeout, 0);

      // Done edge on the last timeout cycle wins
      run_txn(16'd9, 2'b00, 21, 16'h1357, 1, 1'b0);
      // Stale done level
      run_txn(16'd77, 2'b01, 8, 16'h2468, 0, 1'b1);

      // Reset during WAIT
      s_valid = 1'b1; s_data = 16'd100; cfg_sel = 2'b10;
      tick();
      s_valid = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_input", filt_input, 0);
      chk("mid_rst_select", filt_select, 0);
      chk("mid_rst_s_ready", s_ready, 0);
      chk("mid_rst_cnt", sample_cnt, 0);
      exp_cnt = '0;
      tick();
      rst = 1'b0;
      tick();
      run_txn(16'd500, 2'b00, 5, core_model(16'd500, 2'b00), 0, 1'b0);

      // Stream of 50: HPF then LPF
      do_reset();
      for (int i = 0; i < 50; i++) begin
         logic [15:0] smp;
         logic [1:0]  sel;
         smp = 16'($urandom);
         sel = (i < 25) ? 2'b01 : 2'b00;
         run_txn(smp, sel, $urandom_range(2, 15), core_model(smp, sel), $urandom_range(0, 3), 1'b0);
      end
      chk("stream_cnt", sample_cnt, 50);
      chk("stream_err", err_timeout, 0);
      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
